// File: rtl/fetch_queue_pipe.sv
// ---------------------------------------------------------------------------
// fetch_queue_pipe
//   IF/ID boundary. Holds up to DEPTH {pc, instr} pairs in order between
//   fetch and decode. Provides a valid/ready handshake on both sides, a
//   stall input that holds the head entry, and a flush input that empties
//   the queue and then blocks both sides for FLUSH_CYCLES bubble cycles.
//
// Ports
//   clk        in   1                 clock, all state on posedge
//   rst        in   1                 synchronous active-high reset
//   in_valid   in   1                 fetch presents in_pc/in_instr
//   in_ready   out  1                 queue accepts this cycle
//   in_pc      in   XLEN              fetch pc
//   in_instr   in   XLEN              fetched instruction
//   flush      in   1                 taken jal/jalr/branch redirect
//   stall      in   1                 load-use hazard: hold head, no dequeue
//   out_valid  out  1                 head entry valid to decode
//   out_pc     out  XLEN              head pc (0 when !out_valid)
//   out_instr  out  XLEN              head instr (NOP_INSTR when !out_valid)
//   occupancy  out  $clog2(DEPTH)+1   entries held
// ---------------------------------------------------------------------------
module fetch_queue_pipe #(
  parameter int               XLEN         = 32,
  parameter int               DEPTH        = 2,
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0]  NOP_INSTR    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  input  logic                       flush,
  input  logic                       stall,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [2:0]      bub;
  logic            full;
  logic            enq;
  logic            deq;

  // Handshake is decided purely from registered state plus flush; the data
  // outputs never see in_pc/in_instr combinationally.
  assign full      = (count == CW'(DEPTH));
  assign in_ready  = !flush && (bub == 3'd0) && !full;
  assign out_valid = (count != '0) && (bub == 3'd0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && !stall;

  assign head      = mem[rd_ptr];
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : NOP_INSTR;
  assign occupancy = count;

  // Control state. Flush wins over everything except reset; the bubble
  // counter only counts down when no new flush arrives.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      bub    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
      bub    <= 3'(FLUSH_CYCLES);
    end else begin
      if (bub != 3'd0) bub    <= bub - 3'd1;
      if (enq)         wr_ptr <= wr_ptr + PW'(1);
      if (deq)         rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through out_valid, which depends solely on the reset count/bub.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end
  end

endmodule

// File: tb/tb_fetch_queue_pipe.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_pipe
//   Two instances share one stimulus stream:
//     dut0: DEPTH=2, FLUSH_CYCLES=2, NOP_INSTR=0
//     dut1: DEPTH=4, FLUSH_CYCLES=0, NOP_INSTR=0x13
//   A reference model per instance keeps an ordered list of accepted
//   {pc, instr} pairs and a bubble count. Accepted fetches are pushed at the
//   clock edge; a monitor on the falling edge compares the DUT outputs with
//   the head of the list and the model's handshake expectations.
// ---------------------------------------------------------------------------
module tb_fetch_queue_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic        stall;
  logic [31:0] in_pc;
  logic [31:0] in_instr;

  logic        r0, v0, r1, v1;
  logic [31:0] pc0, ins0, pc1, ins1;
  logic [1:0]  occ0;
  logic [2:0]  occ1;

  always #5 clk = ~clk;

  fetch_queue_pipe #(.XLEN(32), .DEPTH(2), .FLUSH_CYCLES(2), .NOP_INSTR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .stall(stall), .out_valid(v0),
    .out_pc(pc0), .out_instr(ins0), .occupancy(occ0)
  );

  fetch_queue_pipe #(.XLEN(32), .DEPTH(4), .FLUSH_CYCLES(0), .NOP_INSTR(32'h13)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .stall(stall), .out_valid(v1),
    .out_pc(pc1), .out_instr(ins1), .occupancy(occ1)
  );

  // Per-instance views so the model and monitor can loop over both.
  logic        d_ready [2];
  logic        d_valid [2];
  logic [31:0] d_pc    [2];
  logic [31:0] d_instr [2];
  logic [31:0] d_occ   [2];

  always_comb begin
    d_ready[0] = r0;   d_ready[1] = r1;
    d_valid[0] = v0;   d_valid[1] = v1;
    d_pc[0]    = pc0;  d_pc[1]    = pc1;
    d_instr[0] = ins0; d_instr[1] = ins1;
    d_occ[0]   = 32'(occ0);
    d_occ[1]   = 32'(occ1);
  end

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int fc_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] nop_of(input int k);
    return (k == 0) ? 32'h0 : 32'h13;
  endfunction

  // Reference model: sb[k][0..msize-1] is the in-order list of entries
  // accepted and not yet consumed; element 0 is what decode should see.
  logic [63:0] sb    [2][8];
  int          msize [2];
  int          mbub  [2];
  bit          run = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
  endtask

  function automatic bit exp_ready(input int k);
    return !flush && (mbub[k] == 0) && (msize[k] < depth_of(k));
  endfunction

  function automatic bit exp_valid(input int k);
    return (msize[k] > 0) && (mbub[k] == 0);
  endfunction

  // Model update at the edge: reset, then flush, then normal enq/deq.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit acc, pop;
      acc = in_valid && exp_ready(k);
      pop = exp_valid(k) && !stall;
      if (rst) begin
        msize[k] = 0;
        mbub[k]  = 0;
      end else if (flush) begin
        msize[k] = 0;
        mbub[k]  = fc_of(k);
      end else begin
        if (mbub[k] > 0) mbub[k]--;
        if (pop) begin
          for (int i = 0; i < 7; i++) sb[k][i] = sb[k][i+1];
          msize[k]--;
        end
        if (acc) begin
          sb[k][msize[k]] = {in_pc, in_instr};
          msize[k]++;
        end
      end
    end
  end

  // Monitor: compare everything away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] e_pc, e_instr;
        e_pc    = exp_valid(k) ? sb[k][0][63:32] : 32'h0;
        e_instr = exp_valid(k) ? sb[k][0][31:0]  : nop_of(k);
        check("in_ready",  k, 32'(d_ready[k]), 32'(exp_ready(k)));
        check("out_valid", k, 32'(d_valid[k]), 32'(exp_valid(k)));
        check("occupancy", k, d_occ[k], 32'(msize[k]));
        check("out_pc",    k, d_pc[k],    e_pc);
        check("out_instr", k, d_instr[k], e_instr);
      end
    end
  end

  logic [31:0] next_pc = 32'h0;

  task automatic cyc(input bit iv, input bit fl, input bit st);
    in_valid = iv;
    flush    = fl;
    stall    = st;
    in_pc    = next_pc;
    in_instr = $urandom;
    next_pc  = next_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_instr(input bit iv, input logic [31:0] ins);
    in_valid = iv;
    flush    = 1'b0;
    stall    = 1'b0;
    in_pc    = next_pc;
    in_instr = ins;
    next_pc  = next_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    in_pc = '0; in_instr = '0;
    @(posedge clk); #1;
    run = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Straight-line stream of three instructions, no stall.
    next_pc = 32'h0;
    cyc_instr(1'b1, 32'h00500093);
    cyc_instr(1'b1, 32'h00A00113);
    cyc_instr(1'b1, 32'h002081B3);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Stream, then hold the head for four cycles, then drain.
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0);

    // Fill, flush, then refetch from 0x100.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    next_pc = 32'h100;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0);

    // Flush with stall and in_valid together, then a second flush.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);

    // Reset in the middle of a full queue.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cyc($urandom_range(0, 3) != 0,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) == 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
